dp_memory: RTL and testbench
============================

DP_MEMORY -- requirements
Module: dp_memory

Interface
REQ-001 Parameter: RAM_WIDTH, 16, data word width in bits.
REQ-002 Parameter: RAM_ADDR_BITS, 15, address width; depth = 2**RAM_ADDR_BITS words.
REQ-003 Parameter: READ_LATENCY, 1, read latency in cycles; legal values 1 or 2.
REQ-004 Parameter: MODE_A, 0, port A write mode; 0 = write-first, 1 = read-first, 2 = no-change.
REQ-005 Parameter: MODE_B, 0, port B write mode; encoding as MODE_A.
REQ-006 Parameter: CLEAR_VALUE, 0, RAM_WIDTH-bit word written by the clear engine.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 enA / weA  in  1 / 1  port A enable / write enable.
REQ-010 addrA / dinA  in  RAM_ADDR_BITS / RAM_WIDTH  port A address / write data.
REQ-011 doutA  out  RAM_WIDTH  port A read data.
REQ-012 enB / weB  in  1 / 1  port B enable / write enable.
REQ-013 addrB / dinB  in  RAM_ADDR_BITS / RAM_WIDTH  port B address / write data; port B has its own data input.
REQ-014 doutB  out  RAM_WIDTH  port B read data.
REQ-015 clr_start  in  1  one-cycle request to start a region clear.
REQ-016 clr_base / clr_count  in  RAM_ADDR_BITS / RAM_ADDR_BITS+1  first address / number of words to clear.
REQ-017 clr_busy / clr_done  out  1 / 1  clear in progress / one-cycle completion pulse.
REQ-018 collision  out  1  one-cycle flag for a same-address port conflict.

Function
REQ-019 Each port SHALL access the array only in cycles where its enable is 1; with enable 0, the port's output pipeline SHALL hold its value.
REQ-020 Port writes: weX=1 SHALL write dinX to the array at addrX at the clock edge.
REQ-021 Write-mode output: write-first SHALL present dinX; read-first SHALL present the pre-write contents; no-change SHALL hold the previous output.
REQ-022 Read, READ_LATENCY=1: data SHALL appear on doutX one cycle after the access edge.
REQ-023 Read, READ_LATENCY=2: an extra register stage SHALL add one cycle of latency; the stage SHALL advance only when that port's enable was 1 in the previous cycle.
REQ-024 Collision: when both ports are enabled at the same address and at least one writes, collision SHALL be 1 in the following cycle only.
REQ-025 Both ports write the same address: port A data SHALL be stored.
REQ-026 One port writes and the other reads the same address: the reader SHALL receive the pre-write contents.
REQ-027 Clear FSM states: IDLE, CLEAR, DONE.
REQ-028 In IDLE, clr_start=1 with clr_count>0 SHALL go to CLEAR, loading ptr=clr_base and remaining=clr_count.
REQ-029 In IDLE, clr_start=1 with clr_count=0 SHALL go directly to DONE.
REQ-030 In CLEAR, the engine SHALL write CLEAR_VALUE at ptr each cycle, then increment ptr modulo depth (wrap-around) and decrement remaining.
REQ-031 In CLEAR, the FSM SHALL go to DONE after the write made when remaining=1.
REQ-032 DONE SHALL assert clr_done for one cycle, then return to IDLE.
REQ-033 clr_busy SHALL be 1 in CLEAR and DONE, else 0.
REQ-034 A clear of N words SHALL assert clr_busy for exactly N+1 cycles.
REQ-035 clr_start SHALL be ignored while clr_busy=1.
REQ-036 clr_count = 2**RAM_ADDR_BITS SHALL clear the entire array exactly once.
REQ-037 While clr_busy=1, the engine SHALL own port A: enA/weA SHALL be ignored, doutA SHALL hold, and collision SHALL treat the engine's write as a port A write.
REQ-038 Port B SHALL stay fully operational during a clear.

Reset
REQ-039 reset=0 SHALL immediately force doutA=0, doutB=0, both READ_LATENCY=2 stage registers to 0, collision=0, clr_busy=0, clr_done=0, and FSM=IDLE.
REQ-040 Array contents SHALL NOT be affected by reset.
REQ-041 Reset asserted mid-clear SHALL abort the clear; already-cleared words SHALL keep CLEAR_VALUE and the remaining words SHALL be unchanged.
REQ-042 Following reset deassertion, the first accepted access SHALL be at the next rising clk edge.

Verification
REQ-043 Latency 1, write-first: A writes 0x1234 @0x0010, next cycle B reads 0x0010 -> doutB=0x1234 one cycle later; doutA=0x1234 on the write cycle +1.
REQ-044 Read-first vs no-change: word holds 0xAAAA, A writes 0x5555 -> doutA=0xAAAA (MODE_A=1) / previous doutA (MODE_A=2); array reads 0x5555 afterward.
REQ-045 Same-cycle collision: A writes 0x1111, B writes 0x2222 @0x0020 -> collision=1 one cycle later; subsequent read of 0x0020 returns 0x1111.
REQ-046 Clear with wrap-around: clr_base=0x7FFE, clr_count=4 -> addresses 0x7FFE,0x7FFF,0x0000,0x0001 equal CLEAR_VALUE; clr_busy high 5 cycles; clr_done pulses once; 0x0002 unchanged.
REQ-047 Reset mid-clear: clr_count=8, reset=0 after 3 write cycles -> outputs 0 at once; exactly 3 words cleared; clr_busy=0.
REQ-048 READ_LATENCY=2: B reads 0x0005 holding 0xBEEF with enB held 1 -> doutB=0xBEEF exactly 2 cycles after the request; clr_count=0 -> clr_done pulse one cycle later with no writes.

Source files
------------

// File: rtl/dp_memory.sv
// -----------------------------------------------------------------------------
// dp_memory
//   True dual-port RAM with a built-in region clear engine.
//
//   Parameters
//     RAM_WIDTH     : data word width
//     RAM_ADDR_BITS : address width, depth = 2**RAM_ADDR_BITS
//     READ_LATENCY  : 1 or 2 cycles from access edge to dout
//     MODE_A/MODE_B : 0 = write-first, 1 = read-first, 2 = no-change
//     CLEAR_VALUE   : word written by the clear engine
//
//   Ports
//     clk, reset                 : clock, async active-low reset
//     enA/weA/addrA/dinA/doutA   : port A (owned by the clear engine while busy)
//     enB/weB/addrB/dinB/doutB   : port B (always available)
//     clr_start/base/count       : start a clear of count words from base
//     clr_busy/clr_done          : clear running / one-cycle completion pulse
//     collision                  : same-address conflict seen on previous edge
//     clr_state                  : clear FSM state (debug visibility)
// -----------------------------------------------------------------------------
module dp_memory #(
    parameter int                   RAM_WIDTH     = 16,
    parameter int                   RAM_ADDR_BITS = 15,
    parameter int                   READ_LATENCY  = 1,
    parameter int                   MODE_A        = 0,
    parameter int                   MODE_B        = 0,
    parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enA,
    input  logic                     weA,
    input  logic [RAM_ADDR_BITS-1:0] addrA,
    input  logic [RAM_WIDTH-1:0]     dinA,
    output logic [RAM_WIDTH-1:0]     doutA,
    input  logic                     enB,
    input  logic                     weB,
    input  logic [RAM_ADDR_BITS-1:0] addrB,
    input  logic [RAM_WIDTH-1:0]     dinB,
    output logic [RAM_WIDTH-1:0]     doutB,
    input  logic                     clr_start,
    input  logic [RAM_ADDR_BITS-1:0] clr_base,
    input  logic [RAM_ADDR_BITS:0]   clr_count,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     collision,
    output logic [1:0]               clr_state
);

    localparam int DEPTH = 2**RAM_ADDR_BITS;
    localparam logic [RAM_ADDR_BITS-1:0] PTR_ONE = 1;
    localparam logic [RAM_ADDR_BITS:0]   REM_ONE = 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_DONE = 2'd2} clr_state_t;

    logic [RAM_WIDTH-1:0] mem [DEPTH];

    clr_state_t               state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [RAM_ADDR_BITS:0]   rem_q, rem_d;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    if (clr_count != '0) begin
                        state_d = S_CLEAR;
                        ptr_d   = clr_base;
                        rem_d   = clr_count;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                // ptr is exactly RAM_ADDR_BITS wide, so the increment wraps modulo depth.
                ptr_d = ptr_q + PTR_ONE;
                rem_d = rem_q - REM_ONE;
                if (rem_q == REM_ONE) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign clr_busy  = (state_q != S_IDLE);
    assign clr_done  = (state_q == S_DONE);
    assign clr_state = state_q;

    // ---------------- port A arbitration ----------------
    // While busy the user side of port A is locked out; the engine writes only in CLEAR.
    logic                     eng_we;
    logic                     user_a_en;
    logic                     mem_a_en;
    logic                     mem_a_we;
    logic [RAM_ADDR_BITS-1:0] mem_a_addr;
    logic [RAM_WIDTH-1:0]     mem_a_din;

    assign eng_we     = (state_q == S_CLEAR);
    assign user_a_en  = enA && !clr_busy;
    assign mem_a_en   = eng_we || user_a_en;
    assign mem_a_we   = eng_we || (user_a_en && weA);
    assign mem_a_addr = eng_we ? ptr_q : addrA;
    assign mem_a_din  = eng_we ? CLEAR_VALUE : dinA;

    // Array has no reset. Port A is written last so it wins a same-address double write.
    always_ff @(posedge clk) begin
        if (enB && weB)   mem[addrB]      <= dinB;
        if (mem_a_we)     mem[mem_a_addr] <= mem_a_din;
    end

    // ---------------- first read stage ----------------
    // Reading mem here returns the pre-edge contents, which gives read-first
    // behaviour and lets a reader see old data when the other port writes.
    logic [RAM_WIDTH-1:0] a_q1, b_q1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q1 <= '0;
        end else if (user_a_en) begin
            if (!weA || MODE_A == 1) a_q1 <= mem[addrA];
            else if (MODE_A == 0)    a_q1 <= dinA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_q1 <= '0;
        end else if (enB) begin
            if (!weB || MODE_B == 1) b_q1 <= mem[addrB];
            else if (MODE_B == 0)    b_q1 <= dinB;
        end
    end

    // ---------------- collision flag ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) collision <= 1'b0;
        else        collision <= mem_a_en && enB && (mem_a_addr == addrB) && (mem_a_we || weB);
    end

    // ---------------- optional second read stage ----------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [RAM_WIDTH-1:0] a_q2, b_q2;
            logic                 a_en_d, b_en_d;

            // The second stage only moves when the port accessed on the previous edge.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    a_q2   <= '0;
                    b_q2   <= '0;
                    a_en_d <= 1'b0;
                    b_en_d <= 1'b0;
                end else begin
                    a_en_d <= user_a_en;
                    b_en_d <= enB;
                    if (a_en_d) a_q2 <= a_q1;
                    if (b_en_d) b_q2 <= b_q1;
                end
            end
            assign doutA = a_q2;
            assign doutB = b_q2;
        end else begin : g_lat1
            assign doutA = a_q1;
            assign doutB = b_q1;
        end
    endgenerate

endmodule

// File: tb/tb_dp_memory.sv
// -----------------------------------------------------------------------------
// tb_dp_memory
//   Three dp_memory instances share one stimulus stream:
//     u0 : write-first, latency 1
//     u1 : port A read-first, latency 2
//     u2 : port A no-change, latency 1
//   All use CLEAR_VALUE = 16'hC1C1 so cleared words are distinguishable.
// -----------------------------------------------------------------------------
module tb_dp_memory;

    localparam int W  = 16;
    localparam int AB = 15;
    localparam logic [W-1:0] CV = 16'hC1C1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          enA = 0, weA = 0, enB = 0, weB = 0;
    logic [AB-1:0] addrA = '0, addrB = '0;
    logic [W-1:0]  dinA = '0, dinB = '0;
    logic          clr_start = 0;
    logic [AB-1:0] clr_base = '0;
    logic [AB:0]   clr_count = '0;

    logic [W-1:0] douta [3];
    logic [W-1:0] doutb [3];
    logic         coll  [3];
    logic         busy  [3];
    logic         done  [3];
    logic [1:0]   st    [3];

    dp_memory #(.CLEAR_VALUE(CV)) u0 (
        .clk(clk), .reset(reset),
        .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(douta[0]),
        .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutb[0]),
        .clr_start(clr_start), .clr_base(clr_base), .clr_count(clr_count),
        .clr_busy(busy[0]), .clr_done(done[0]), .collision(coll[0]), .clr_state(st[0])
    );

    dp_memory #(.MODE_A(1), .READ_LATENCY(2), .CLEAR_VALUE(CV)) u1 (
        .clk(clk), .reset(reset),
        .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(douta[1]),
        .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutb[1]),
        .clr_start(clr_start), .clr_base(clr_base), .clr_count(clr_count),
        .clr_busy(busy[1]), .clr_done(done[1]), .collision(coll[1]), .clr_state(st[1])
    );

    dp_memory #(.MODE_A(2), .CLEAR_VALUE(CV)) u2 (
        .clk(clk), .reset(reset),
        .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(douta[2]),
        .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutb[2]),
        .clr_start(clr_start), .clr_base(clr_base), .clr_count(clr_count),
        .clr_busy(busy[2]), .clr_done(done[2]), .collision(coll[2]), .clr_state(st[2])
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        else             n_pass++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic port_a(input logic en, input logic we, input logic [AB-1:0] a, input logic [W-1:0] d);
        enA = en; weA = we; addrA = a; dinA = d;
    endtask

    task automatic port_b(input logic en, input logic we, input logic [AB-1:0] a, input logic [W-1:0] d);
        enB = en; weB = we; addrB = a; dinB = d;
    endtask

    // Two edges so the latency-2 instance also presents the word.
    task automatic rd_b(input logic [AB-1:0] a, input logic [W-1:0] exp, input string tag);
        port_b(1, 0, a, '0);
        tick();
        port_b(0, 0, '0, '0);
        tick();
        for (int i = 0; i < 3; i++) check($sformatf("%s_u%0d", tag, i), doutb[i], exp);
    endtask

    int busy_cyc;
    int done_cnt;

    initial begin
        // ---- reset state ----
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_douta_u%0d", i), douta[i], 0);
            check($sformatf("rst_doutb_u%0d", i), doutb[i], 0);
            check($sformatf("rst_busy_u%0d", i), busy[i], 0);
            check($sformatf("rst_done_u%0d", i), done[i], 0);
            check($sformatf("rst_state_u%0d", i), st[i], 0);
        end
        check("rst_coll", coll[0], 0);
        @(negedge clk);
        reset = 1'b1;

        // ---- write-first, latency 1 ----
        port_a(1, 1, 15'h0010, 16'h1234);
        tick();
        check("wf_douta", douta[0], 16'h1234);
        check("nc_douta_init", douta[2], 16'h0000);
        port_a(0, 0, '0, '0);
        port_b(1, 0, 15'h0010, '0);
        tick();
        check("b_read_lat1", doutb[0], 16'h1234);
        check("b_read_lat2_early", doutb[1], 16'h0000);

        // ---- latency 2 with enB held high ----
        port_a(1, 1, 15'h0005, 16'hBEEF);
        port_b(1, 0, 15'h0010, '0);
        tick();
        check("lat2_first", doutb[1], 16'h1234);
        port_a(0, 0, '0, '0);
        port_b(1, 0, 15'h0005, '0);
        tick();
        check("beef_lat1", doutb[0], 16'hBEEF);
        check("beef_lat2_1cyc", doutb[1], 16'h1234);
        tick();
        check("beef_lat2_2cyc", doutb[1], 16'hBEEF);
        port_b(0, 0, '0, '0);
        tick();
        check("b_hold", doutb[0], 16'hBEEF);

        // ---- read-first / no-change ----
        port_a(1, 1, 15'h0030, 16'hAAAA);
        tick();
        check("wf_aaaa", douta[0], 16'hAAAA);
        check("nc_hold_1", douta[2], 16'h0000);
        port_a(1, 1, 15'h0030, 16'h5555);
        tick();
        check("wf_5555", douta[0], 16'h5555);
        check("nc_hold_2", douta[2], 16'h0000);
        port_a(1, 0, 15'h0030, '0);
        tick();
        check("rf_old_data", douta[1], 16'hAAAA);
        check("nc_read_new", douta[2], 16'h5555);
        port_a(0, 0, '0, '0);
        tick();
        check("rf_read_new", douta[1], 16'h5555);

        // ---- collisions ----
        port_a(1, 1, 15'h0020, 16'h1111);
        port_b(1, 1, 15'h0020, 16'h2222);
        tick();
        check("coll_ww", coll[0], 1);
        port_a(0, 0, '0, '0);
        port_b(1, 0, 15'h0020, '0);
        tick();
        check("coll_clear", coll[0], 0);
        check("a_wins", doutb[0], 16'h1111);
        port_a(1, 1, 15'h0020, 16'h3333);
        port_b(1, 0, 15'h0020, '0);
        tick();
        check("coll_wr", coll[0], 1);
        check("rd_pre_write", doutb[0], 16'h1111);
        port_a(0, 0, '0, '0);
        port_b(0, 0, '0, '0);
        tick();
        check("coll_idle", coll[0], 0);

        // ---- clear with wrap-around ----
        port_a(1, 1, 15'h0002, 16'h7777);
        port_b(1, 1, 15'h0001, 16'h4444);
        tick();
        check("coll_diff_addr", coll[0], 0);
        port_b(0, 0, '0, '0);
        port_a(1, 1, 15'h7FFE, 16'h1357);
        tick();
        port_a(1, 0, 15'h0002, '0);
        tick();
        check("pre_clear_douta", douta[0], 16'h7777);
        port_a(0, 0, '0, '0);
        clr_start = 1; clr_base = 15'h7FFE; clr_count = 16'd4;
        tick();
        // Hold a conflicting request and port A traffic; both must be ignored while busy.
        clr_base = 15'h0002; clr_count = 16'd1;
        port_a(1, 1, 15'h0003, 16'hDEAD);
        port_b(1, 0, 15'h0030, '0);
        busy_cyc = busy[0] ? 1 : 0;
        done_cnt = done[0] ? 1 : 0;
        check("clear_state", st[0], 1);
        for (int i = 0; i < 20 && busy[0]; i++) begin
            tick();
            busy_cyc += busy[0] ? 1 : 0;
            done_cnt += done[0] ? 1 : 0;
        end
        clr_start = 0;
        port_a(0, 0, '0, '0);
        port_b(0, 0, '0, '0);
        check("busy_cycles", busy_cyc, 5);
        check("done_pulses", done_cnt, 1);
        check("busy_low", busy[0], 0);
        check("douta_hold_busy", douta[0], 16'h7777);
        check("b_during_clear", doutb[0], 16'h5555);
        rd_b(15'h7FFE, CV, "clr_7ffe");
        rd_b(15'h7FFF, CV, "clr_7fff");
        rd_b(15'h0000, CV, "clr_0000");
        rd_b(15'h0001, CV, "clr_0001");
        rd_b(15'h0002, 16'h7777, "keep_0002");

        // ---- reset mid-clear ----
        for (int i = 0; i < 4; i++) begin
            port_a(1, 1, 15'h0100 + 15'(i), 16'h9999);
            tick();
        end
        port_a(0, 0, '0, '0);
        clr_start = 1; clr_base = 15'h0100; clr_count = 16'd8;
        tick();
        clr_start = 0;
        tick(); tick(); tick();
        check("busy_mid_clear", busy[0], 1);
        reset = 1'b0;
        #1;
        check("abort_busy", busy[0], 0);
        check("abort_done", done[0], 0);
        check("abort_state", st[0], 0);
        check("abort_douta", douta[0], 0);
        check("abort_doutb", doutb[0], 0);
        check("abort_doutb_lat2", doutb[1], 0);
        check("abort_douta_lat2", douta[1], 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_rst_busy", busy[0], 0);
        rd_b(15'h0100, CV, "abort_0100");
        rd_b(15'h0101, CV, "abort_0101");
        rd_b(15'h0102, CV, "abort_0102");
        rd_b(15'h0103, 16'h9999, "abort_0103");

        // ---- zero-length clear ----
        clr_start = 1; clr_base = 15'h0010; clr_count = '0;
        tick();
        clr_start = 0;
        check("zero_busy", busy[0], 1);
        check("zero_done", done[0], 1);
        tick();
        check("zero_done_end", done[0], 0);
        check("zero_busy_end", busy[0], 0);
        rd_b(15'h0010, 16'h1234, "zero_nowrite");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
